uart_rx_fifo: RTL and testbench
===============================

Name: uart_rx_fifo

Overview:
Parametrised successor to the single-byte UART receiver. It adds configurable frame format (data bits, parity, stop bits) and glitch-tolerant majority sampling. Received characters are buffered in a small FIFO with per-character error flags, so the CPU-side bus adapter can pop them without the go/dr lock-step and without losing back-to-back characters. It sits between the board RX pin and the memory-mapped UART register block.

Parameters:
CLK_FREQ, 66_000_000, system clock frequency in Hz
BAUD_RATE, 9600, line rate; BIT_TIME = CLK_FREQ / BAUD_RATE, must be >= 8
DATA_BITS, 8, data bits per character, legal range 5..8
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, 1 or 2
FIFO_DEPTH, 4, character slots, power of two, >= 2

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
rx  in  1  asynchronous serial line, idle high
rd  in  1  pop head entry this cycle; ignored when dr = 0
data  out  DATA_BITS  head entry data, LSB received first; 0 when empty
dr  out  1  FIFO not empty (head valid)
frame_err  out  1  head entry had a stop bit sampled low; 0 when empty
parity_err  out  1  head entry failed parity; always 0 when PARITY = 0
overrun  out  1  sticky: a completed character was dropped because the FIFO was full
clr_err  in  1  clears overrun next cycle; if a drop occurs in the same cycle, overrun stays 1
count  out  $clog2(FIFO_DEPTH)+1  occupancy

Behaviour:
- Reset (async assert, sync release): state IDLE, FIFO empty, and all outputs 0. The synchroniser flops reset to 1.
- rx passes through a 2-flop synchroniser (rx_s). All decisions use rx_s.
- Sample point: majority of rx_s at bit_counter = H+1, H, H-1, where H = BIT_TIME/2. The bit value is latched at H-1.
- bit_counter loads BIT_TIME-1 at each bit boundary and counts down to 0.
- State machine: IDLE, START, DATA, PARITY, STOP1, STOP2, BREAK.
- IDLE: a falling edge on rx_s (1 then 0) loads bit_counter = BIT_TIME-2 and enters START.
- START: at the sample point, a majority of 1 is a false start and returns to IDLE with no push. Otherwise continue. At 0, enter DATA with bit index 0.
- DATA: shift the sampled bit into bit position index. After bit DATA_BITS-1 reaches 0, enter PARITY (PARITY != 0) or STOP1.
- PARITY: for odd parity, the XOR of data and parity bit must be 1; for even parity, it must be 0. A mismatch records parity_err for the character.
- STOP1 and STOP2 (STOP2 only when STOP_BITS = 2): a stop sample of 0 records frame_err.
- Character completion happens at the sample cycle of the last stop bit, not at its end, to allow resynchronisation. The push occurs that cycle; the receiver returns to IDLE next cycle, or to BREAK if frame_err was recorded.
- BREAK: wait for rx_s = 1, then go to IDLE. No pushes occur in BREAK.
- Push latency: dr/data/flags are visible 1 cycle after the completing sample cycle when the FIFO was empty.
- FIFO entry = {parity_err, frame_err, data}.
- Full: a push is accepted if count < FIFO_DEPTH or rd is asserted with dr = 1 in the same cycle. Otherwise the character is dropped and overrun is set.
- Empty: rd is ignored and count stays 0.
- Simultaneous push and pop: count is unchanged and the head advances.
- Pointers wrap modulo FIFO_DEPTH.
- rst_n asserted mid-character aborts the character immediately. The partial character is discarded and the FIFO is flushed.

Decomposition:
- Package uart_pkg holds:
  - PARITY_NONE, PARITY_ODD, and PARITY_EVEN constants
  - the receive state encoding localparams
  - a shared function computing BIT_TIME and counter width, for reuse by the future parametrised transmitter
- Sub-module uart_fifo: synchronous FIFO with parameters WIDTH and DEPTH, ports push, pop, din, dout, count, full, and empty. It uses the same clk and rst_n.

Test Plan:
- CLK_FREQ=160, BAUD_RATE=10 (BIT_TIME 16), 8N1. Send 0xA5 → dr rises 1 cycle after the stop-bit sample; data = 0xA5, both error flags 0; rd pops → dr = 0, data = 0.
- 7E1: send 0x41 with parity bit 0 → data 0x41, parity_err 0. Send 0x41 with parity bit 1 → parity_err 1, and the entry is still pushed.
- 8N1, FIFO_DEPTH 4, no rd. Send 0x01..0x05 back-to-back → count = 4, overrun = 1, and pops return 0x01..0x04. clr_err → overrun 0.
- Glitch tests: a 3-cycle low pulse on idle rx → false start, no push, count 0. A single-cycle inverted spike at the mid data bit of 0x55 → the majority vote yields 0x55.
- Break: hold rx low for 20 bit times → one entry with data 0x00 and frame_err 1, and no further pushes until rx returns high. The next character, 0x3C, is received correctly.
- Reset mid-frame: assert rst_n low during data bit 4 with 2 entries queued → dr = 0 and count = 0 immediately. After release, send 0x7E → it is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared UART constants, receive state encoding and bit-timing helpers
//   PARITY_*    : parity mode selectors for the PARITY parameter
//   rx_state_t  : receiver state encoding
//   bit_time()  : clock cycles per bit; cnt_width() : width of a bit-timing down-counter
package uart_pkg;
  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP1  = 3'd4,
    S_STOP2  = 3'd5,
    S_BREAK  = 3'd6
  } rx_state_t;

  function automatic int bit_time(input int clk_freq, input int baud_rate);
    return clk_freq / baud_rate;
  endfunction

  function automatic int cnt_width(input int clk_freq, input int baud_rate);
    return $clog2(clk_freq / baud_rate);
  endfunction
endpackage

// File: rtl/uart_fifo.sv
// uart_fifo: synchronous FIFO with occupancy count
//   clk, rst_n : clock, asynchronous active-low reset
//   push, din  : write din when not full (or when a pop happens the same cycle)
//   pop, dout  : advance head when not empty; dout is the head entry
//   count      : occupancy; full / empty status flags
module uart_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [AW:0] r_cnt;
  logic w_pop, w_push;

  assign empty  = r_cnt == '0;
  assign full   = r_cnt == FULL_CNT;
  assign w_pop  = pop && !empty;
  assign w_push = push && (!full || w_pop);
  assign dout   = r_mem[r_rp];
  assign count  = r_cnt;

  always_ff @(posedge clk)
    if (w_push) r_mem[r_wp] <= din;

  // pointers are exactly AW bits wide, so they wrap modulo DEPTH for free
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + AW'(1);
      if (w_pop) r_rp <= r_rp + AW'(1);
      r_cnt <= r_cnt + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};
    end
endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: configurable UART receiver with majority sampling and an error-tagged receive FIFO
//   clk, rst_n : clock, asynchronous active-low reset
//   rx         : asynchronous serial line, idle high
//   rd         : pop head entry (ignored when empty)
//   data, frame_err, parity_err : head entry, all 0 when empty
//   dr         : head valid; count : occupancy
//   overrun    : sticky character-dropped flag, cleared by clr_err
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 66_000_000,
  parameter int BAUD_RATE  = 9600,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          rx,
  input  logic                          rd,
  input  logic                          clr_err,
  output logic [DATA_BITS-1:0]          data,
  output logic                          dr,
  output logic                          frame_err,
  output logic                          parity_err,
  output logic                          overrun,
  output logic [$clog2(FIFO_DEPTH):0]   count
);
  localparam int BT = bit_time(CLK_FREQ, BAUD_RATE);
  localparam int CW = cnt_width(CLK_FREQ, BAUD_RATE);
  localparam int EW = DATA_BITS + 2;
  localparam logic [CW-1:0] C_LOAD  = CW'(BT - 1);
  localparam logic [CW-1:0] C_START = CW'(BT - 2);
  localparam logic [CW-1:0] C_S0    = CW'(BT / 2 + 1);
  localparam logic [CW-1:0] C_S1    = CW'(BT / 2);
  localparam logic [CW-1:0] C_S2    = CW'(BT / 2 - 1);

  rx_state_t r_state, w_state_n;
  logic r_rx_m, r_rx_s, r_rx_p;
  logic [CW-1:0] r_cnt;
  logic [2:0] r_idx;
  logic [1:0] r_smp;
  logic [DATA_BITS-1:0] r_data;
  logic r_perr, r_ferr, r_ovr;
  logic w_fall, w_smp, w_end, w_maj, w_last, w_ferr, w_done, w_full, w_empty, w_drop;
  logic [EW-1:0] w_dout;

  assign w_fall = r_rx_p & ~r_rx_s;
  assign w_smp  = r_cnt == C_S2;
  assign w_end  = r_cnt == '0;
  // the two earlier samples plus the live value form the 3-way vote
  assign w_maj  = (r_smp[1] & r_smp[0]) | (r_smp[1] & r_rx_s) | (r_smp[0] & r_rx_s);
  assign w_last = r_idx == 3'(DATA_BITS - 1);
  assign w_ferr = r_ferr | ~w_maj;
  // completing at the last stop sample leaves half a bit to resynchronise on the next start edge
  assign w_done = w_smp && (r_state == S_STOP2 || (r_state == S_STOP1 && STOP_BITS == 1));
  assign w_drop = w_done & w_full & ~rd;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= S_IDLE;
    else r_state <= w_state_n;

  always_comb begin
    w_state_n = r_state;
    case (r_state)
      S_IDLE:   w_state_n = w_fall ? S_START : S_IDLE;
      S_START:  w_state_n = (w_smp && w_maj) ? S_IDLE : w_end ? S_DATA : S_START;
      S_DATA:   w_state_n = !(w_end && w_last) ? S_DATA : (PARITY != PARITY_NONE) ? S_PARITY : S_STOP1;
      S_PARITY: w_state_n = w_end ? S_STOP1 : S_PARITY;
      S_STOP1:  w_state_n = w_done ? (w_ferr ? S_BREAK : S_IDLE) : w_end ? S_STOP2 : S_STOP1;
      S_STOP2:  w_state_n = w_done ? (w_ferr ? S_BREAK : S_IDLE) : S_STOP2;
      S_BREAK:  w_state_n = r_rx_s ? S_IDLE : S_BREAK;
      default:  w_state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_rx_m <= 1'b1;
      r_rx_s <= 1'b1;
      r_rx_p <= 1'b1;
      r_cnt  <= '0;
      r_idx  <= '0;
      r_smp  <= '0;
      r_data <= '0;
      r_perr <= 1'b0;
      r_ferr <= 1'b0;
      r_ovr  <= 1'b0;
    end else begin
      r_rx_m <= rx;
      r_rx_s <= r_rx_m;
      r_rx_p <= r_rx_s;
      // the edge is seen one cycle into the start bit, hence BT-2
      r_cnt <= (r_state == S_IDLE && w_fall) ? C_START : w_end ? C_LOAD : r_cnt - CW'(1);
      if (r_cnt == C_S0) r_smp[1] <= r_rx_s;
      if (r_cnt == C_S1) r_smp[0] <= r_rx_s;
      if (r_state == S_IDLE && w_fall) begin
        r_perr <= 1'b0;
        r_ferr <= 1'b0;
      end
      if (r_state == S_START && w_end) r_idx <= '0;
      if (r_state == S_DATA && w_smp) r_data[r_idx] <= w_maj;
      if (r_state == S_DATA && w_end) r_idx <= r_idx + 3'd1;
      if (r_state == S_PARITY && w_smp) r_perr <= (^r_data) ^ w_maj ^ (PARITY == PARITY_ODD);
      if (r_state == S_STOP1 && w_smp) r_ferr <= ~w_maj;
      r_ovr <= w_drop | (r_ovr & ~clr_err);
    end

  uart_fifo #(.WIDTH(EW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (w_done),
    .pop   (rd),
    .din   ({r_perr, w_ferr, r_data}),
    .dout  (w_dout),
    .count (count),
    .full  (w_full),
    .empty (w_empty)
  );

  assign dr         = ~w_empty;
  assign data       = w_empty ? '0 : w_dout[DATA_BITS-1:0];
  assign frame_err  = ~w_empty & w_dout[DATA_BITS];
  assign parity_err = ~w_empty & w_dout[DATA_BITS+1];
  assign overrun    = r_ovr;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: scoreboard bench for uart_rx_fifo in 8N1 and 7E1 configurations
module tb_uart_rx_fifo;
  localparam int BT = 16;

  logic clk = 1'b0, rst_n = 1'b0;
  logic rx8 = 1'b1, rd8 = 1'b0, clr8 = 1'b0, rx7 = 1'b1, rd7 = 1'b0, clr7 = 1'b0;
  logic [7:0] data8;
  logic [6:0] data7;
  logic dr8, fe8, pe8, ov8, dr7, fe7, pe7, ov7;
  logic [2:0] cnt8, cnt7;
  logic [9:0] q8[$];
  logic [9:0] q7[$];
  logic ovr_exp = 1'b0;
  int n_checks = 0, n_pass = 0;

  always #5 clk = ~clk;

  uart_rx_fifo #(.CLK_FREQ(160), .BAUD_RATE(10)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .rx(rx8), .rd(rd8), .clr_err(clr8), .data(data8), .dr(dr8),
    .frame_err(fe8), .parity_err(pe8), .overrun(ov8), .count(cnt8)
  );

  uart_rx_fifo #(.CLK_FREQ(160), .BAUD_RATE(10), .DATA_BITS(7), .PARITY(2)) u_dut7 (
    .clk(clk), .rst_n(rst_n), .rx(rx7), .rd(rd7), .clr_err(clr7), .data(data7), .dr(dr7),
    .frame_err(fe7), .parity_err(pe7), .overrun(ov7), .count(cnt7)
  );

  task automatic drive(input bit sel, input logic [11:0] bits, input int ncyc, input int glitch);
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      if (sel) rx7 = bits[c / BT] ^ (c == glitch);
      else rx8 = bits[c / BT] ^ (c == glitch);
    end
  endtask

  task automatic send8(input logic [7:0] d, input int glitch);
    if (q8.size() < 4) q8.push_back({2'b00, d});
    else ovr_exp = 1'b1;
    drive(1'b0, {2'b00, 1'b1, d, 1'b0}, 10 * BT, glitch);
  endtask

  task automatic send7(input logic [6:0] d, input logic p);
    q7.push_back({1'b0, (^d) ^ p, 1'b0, d});
    drive(1'b1, {2'b00, 1'b1, p, d, 1'b0}, 10 * BT, -1);
  endtask

  task automatic pop(input bit sel, output logic [9:0] got);
    @(negedge clk);
    got = sel ? {1'b0, pe7, fe7, data7} : {pe8, fe8, data8};
    if (sel) rd7 = 1'b1;
    else rd8 = 1'b1;
    @(negedge clk);
    rd7 = 1'b0;
    rd8 = 1'b0;
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({dr8, cnt8, data8, fe8, pe8, ov8} !== '0) $display("FAIL reset8 got %h exp 0", {dr8, cnt8, data8, fe8, pe8, ov8});
    else n_pass++;
    n_checks++;
    if ({dr7, cnt7, data7, fe7, pe7, ov7} !== '0) $display("FAIL reset7 got %h exp 0", {dr7, cnt7, data7, fe7, pe7, ov7});
    else n_pass++;
    rst_n = 1'b1;
    repeat (BT) @(negedge clk);
  endtask

  task automatic test_basic;
    logic [9:0] fr, got, exp;
    int rise;
    rise = -1;
    fr = {1'b1, 8'hA5, 1'b0};
    q8.push_back({2'b00, 8'hA5});
    for (int c = 0; c < 10 * BT; c++) begin
      @(negedge clk);
      if (dr8 && rise < 0) rise = c;
      rx8 = fr[c / BT];
    end
    n_checks++;
    if (rise !== 155) $display("FAIL basic_latency got %0d exp 155", rise);
    else n_pass++;
    pop(1'b0, got);
    exp = q8.pop_front();
    n_checks++;
    if (got !== exp) $display("FAIL basic_data got %h exp %h", got, exp);
    else n_pass++;
    n_checks++;
    if ({dr8, data8, cnt8} !== '0) $display("FAIL basic_empty got %h exp 0", {dr8, data8, cnt8});
    else n_pass++;
  endtask

  task automatic test_parity;
    logic [9:0] got, exp;
    send7(7'h41, 1'b0);
    send7(7'h41, 1'b1);
    n_checks++;
    if (cnt7 !== 3'd2) $display("FAIL parity_count got %0d exp 2", cnt7);
    else n_pass++;
    for (int i = 0; i < 2; i++) begin
      pop(1'b1, got);
      exp = q7.pop_front();
      n_checks++;
      if (got !== exp) $display("FAIL parity_entry%0d got %h exp %h", i, got, exp);
      else n_pass++;
    end
  endtask

  task automatic test_overrun;
    logic [9:0] got, exp;
    for (int i = 1; i <= 5; i++) send8(8'(i), -1);
    n_checks++;
    if (cnt8 !== 3'(q8.size())) $display("FAIL ovr_count got %0d exp %0d", cnt8, q8.size());
    else n_pass++;
    n_checks++;
    if (ov8 !== ovr_exp) $display("FAIL ovr_flag got %b exp %b", ov8, ovr_exp);
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      pop(1'b0, got);
      exp = q8.pop_front();
      n_checks++;
      if (got !== exp) $display("FAIL ovr_pop%0d got %h exp %h", i, got, exp);
      else n_pass++;
    end
    @(negedge clk);
    clr8 = 1'b1;
    @(negedge clk);
    clr8 = 1'b0;
    ovr_exp = 1'b0;
    n_checks++;
    if (ov8 !== ovr_exp) $display("FAIL ovr_clear got %b exp %b", ov8, ovr_exp);
    else n_pass++;
  endtask

  task automatic test_glitch;
    logic [9:0] got, exp;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      rx8 = 1'b0;
    end
    @(negedge clk);
    rx8 = 1'b1;
    repeat (2 * BT) @(negedge clk);
    n_checks++;
    if ({dr8, cnt8} !== '0) $display("FAIL false_start got %h exp 0", {dr8, cnt8});
    else n_pass++;
    send8(8'h55, 4 * BT + 8);
    pop(1'b0, got);
    exp = q8.pop_front();
    n_checks++;
    if (got !== exp) $display("FAIL spike got %h exp %h", got, exp);
    else n_pass++;
  endtask

  task automatic test_break;
    logic [9:0] got, exp;
    q8.push_back({1'b0, 1'b1, 8'h00});
    for (int c = 0; c < 20 * BT; c++) begin
      @(negedge clk);
      rx8 = 1'b0;
    end
    n_checks++;
    if (cnt8 !== 3'd1) $display("FAIL break_count got %0d exp 1", cnt8);
    else n_pass++;
    @(negedge clk);
    rx8 = 1'b1;
    repeat (2 * BT) @(negedge clk);
    n_checks++;
    if ({dr8, fe8, data8, cnt8} !== {1'b1, 1'b1, 8'h00, 3'd1}) $display("FAIL break_head got %h exp %h", {dr8, fe8, data8, cnt8}, {1'b1, 1'b1, 8'h00, 3'd1});
    else n_pass++;
    send8(8'h3C, -1);
    for (int i = 0; i < 2; i++) begin
      pop(1'b0, got);
      exp = q8.pop_front();
      n_checks++;
      if (got !== exp) $display("FAIL break_pop%0d got %h exp %h", i, got, exp);
      else n_pass++;
    end
  endtask

  task automatic test_reset_midframe;
    logic [9:0] got, exp;
    send8(8'h11, -1);
    send8(8'h22, -1);
    drive(1'b0, {2'b00, 1'b1, 8'h99, 1'b0}, 5 * BT + 4, -1);
    @(negedge clk);
    rst_n = 1'b0;
    rx8 = 1'b1;
    q8.delete();
    #1;
    n_checks++;
    if ({dr8, cnt8} !== '0) $display("FAIL midframe_flush got %h exp 0", {dr8, cnt8});
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (BT) @(negedge clk);
    send8(8'h7E, -1);
    pop(1'b0, got);
    exp = q8.pop_front();
    n_checks++;
    if (got !== exp) $display("FAIL midframe_next got %h exp %h", got, exp);
    else n_pass++;
    n_checks++;
    if (cnt8 !== 3'd0) $display("FAIL midframe_count got %0d exp 0", cnt8);
    else n_pass++;
  endtask

  initial begin
    test_reset;
    test_basic;
    test_parity;
    test_overrun;
    test_glitch;
    test_break;
    test_reset_midframe;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
